// File: rtl/logicalunit_sched.sv
// ----------------------------------------------------------------------------
// logicalunit_sched
//
// Bit-serial round-robin scheduler that time-shares a single two-input LUT
// (logicalunit) between N_REQ requesters. An accepted request is pushed
// through the LUT one bit pair per cycle, LSB first. The WIDTH-bit result is
// then returned together with the index of the requester that owns it.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   req_valid   per-requester request valid            [N_REQ]
//   req_ready   per-requester accept strobe, one-hot   [N_REQ]
//   req_a       operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b       operand b, same packing
//   req_func    LUT function, requester i at [i*4 +: 4]
//   resp_valid  result available
//   resp_ready  consumer accepts result
//   resp_data   result vector (partial while running)  [WIDTH]
//   resp_id     owner of resp_data                     [ID_W]
//   busy        high while an operation is running or waiting for hand-off
// ----------------------------------------------------------------------------
module logicalunit_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*4-1:0]     req_func,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WIDTH-1:0]       resp_data,
    output logic [ID_W-1:0]        resp_id,
    output logic                   busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [ID_W-1:0]    lastGrant;
    logic [ID_W-1:0]    grantIdx;
    logic               grantAny;
    logic [WIDTH-1:0]   selA;
    logic [WIDTH-1:0]   selB;
    logic [3:0]         selFunc;
    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;
    logic [3:0]         opFunc;
    logic [CNT_W-1:0]   cnt;
    logic               luOut;

    // Round-robin pick. The winner is the lowest valid index strictly above
    // the previous grant. If there is none, the search wraps around to the
    // lowest valid index overall. Scanning downward lets the last hit in each
    // loop be the lowest index, so no priority chain is needed.
    always_comb begin
        logic       hiFound;
        logic [ID_W-1:0] hiIdx;
        logic       loFound;
        logic [ID_W-1:0] loIdx;
        hiFound = 1'b0;
        hiIdx   = '0;
        loFound = 1'b0;
        loIdx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                loFound = 1'b1;
                loIdx   = ID_W'(i);
                if (i > int'(lastGrant)) begin
                    hiFound = 1'b1;
                    hiIdx   = ID_W'(i);
                end
            end
        end
        grantAny = loFound;
        grantIdx = hiFound ? hiIdx : loIdx;
    end

    // The accept strobe is combinational, so a request is taken on the same
    // edge where req_ready is seen high. Reset forces it low so that nothing
    // can be accepted on a reset edge.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = !rst && (state == IDLE) && grantAny &&
                           (grantIdx == ID_W'(i));
        end
    end

    // Steer the granted requester's operands and function toward the
    // capture registers.
    always_comb begin
        selA    = '0;
        selB    = '0;
        selFunc = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grantIdx == ID_W'(i)) begin
                selA    = req_a[i*WIDTH +: WIDTH];
                selB    = req_b[i*WIDTH +: WIDTH];
                selFunc = req_func[i*4 +: 4];
            end
        end
    end

    // This is the one shared LUT. Only the captured operands, indexed by the
    // bit counter, ever drive it.
    logicalunit luInst (
        .a    (opA[cnt]),
        .b    (opB[cnt]),
        .func (opFunc),
        .out  (luOut)
    );

    // Main FSM. IDLE accepts a request. RUN retires one result bit per cycle.
    // DONE holds the result until the consumer takes it. All visible outputs
    // except req_ready are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            busy       <= 1'b0;
            cnt        <= '0;
            lastGrant  <= ID_W'(N_REQ - 1);
            opA        <= '0;
            opB        <= '0;
            opFunc     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantAny) begin
                        opA       <= selA;
                        opB       <= selB;
                        opFunc    <= selFunc;
                        resp_id   <= grantIdx;
                        lastGrant <= grantIdx;
                        resp_data <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    resp_data[cnt] <= luOut;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// ----------------------------------------------------------------------------
// logicalunit
//
// Two-input lookup table: out = func[{a, b}], with a as the MSB of the index.
//
// Ports:
//   a, b   operand bits
//   func   4-bit truth table
//   out    selected table entry
// ----------------------------------------------------------------------------
module logicalunit (
    input  logic       a,
    input  logic       b,
    input  logic [3:0] func,
    output logic       out
);

    assign out = func[{a, b}];

endmodule

// File: tb/tb_logicalunit_sched.sv
// ----------------------------------------------------------------------------
// tb_logicalunit_sched
//
// Scoreboard bench for logicalunit_sched (N_REQ=4, WIDTH=8), plus a tiny
// WIDTH=1 / N_REQ=1 instance for the degenerate corner. Inputs change at #1
// or #2 after the rising edge. Outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_logicalunit_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N*4-1:0]   req_func;
    logic             resp_valid;
    logic             resp_ready;
    logic [W-1:0]     resp_data;
    logic [IDW-1:0]   resp_id;
    logic             busy;

    logic [0:0]       cValid;
    logic [0:0]       cReady;
    logic [0:0]       cA;
    logic [0:0]       cB;
    logic [3:0]       cFunc;
    logic             cRespValid;
    logic             cRespReady;
    logic [0:0]       cData;
    logic [0:0]       cId;
    logic             cBusy;

    logicalunit_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_func   (req_func),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    logicalunit_sched #(.N_REQ(1), .WIDTH(1)) dutCorner (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (cValid),
        .req_ready  (cReady),
        .req_a      (cA),
        .req_b      (cB),
        .req_func   (cFunc),
        .resp_valid (cRespValid),
        .resp_ready (cRespReady),
        .resp_data  (cData),
        .resp_id    (cId),
        .busy       (cBusy)
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   f;
    } op_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } exp_t;

    op_t          opQ[N][$];
    exp_t         sb[$];
    int           grantLog[$];
    logic [N-1:0] grantedMask;
    int           cyc;
    int           compared;
    int           mismatched;
    int           phase;
    int           acceptCyc;
    int           modelLast;
    int           mg;
    int           actualIdx;
    bit           randomBp;
    bit           prevValid;
    bit           haveHeld;
    exp_t         held;
    exp_t         popped;
    logic [W-1:0] lastRespData;
    logic [IDW-1:0] lastRespId;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [3:0] f);
        op_t o;
        o.a = a;
        o.b = b;
        o.f = f;
        opQ[r].push_back(o);
    endtask

    function automatic bit anyPending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < N; i++) if (opQ[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((anyPending() || phase != 0 || sb.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    // Reference behaviour. Each result bit is the function's truth-table entry
    // at index 2*a+b.
    function automatic logic [W-1:0] refLut(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [3:0] f);
        logic [W-1:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < W; i++) begin
            idx  = 2 * int'(a[i]) + int'(b[i]);
            r[i] = f[idx];
        end
        return r;
    endfunction

    // Round-robin as stated: search upward from the previous grant plus one,
    // wrapping around, and take the first requester that is asking.
    function automatic int rrPick(input logic [N-1:0] v, input int last);
        int i;
        for (int k = 1; k <= N; k++) begin
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Requester driver. Each requester presents the head of its own op queue
    // and keeps it stable until the model reports that it was granted.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (grantedMask[i]) begin
                if (opQ[i].size() != 0) void'(opQ[i].pop_front());
                grantedMask[i] = 1'b0;
            end
            if (opQ[i].size() != 0) begin
                req_valid[i]       = 1'b1;
                req_a[i*W +: W]    = opQ[i][0].a;
                req_b[i*W +: W]    = opQ[i][0].b;
                req_func[i*4 +: 4] = opQ[i][0].f;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (randomBp) resp_ready = ($urandom_range(0, 3) != 0);
    end

    // Transaction-level model of the scheduler. It is either free or holding
    // one operation. Being free means it grants by round-robin and pushes the
    // expected result. Holding an operation means the result is due W+1
    // falling edges after the grant was seen, and it is released on the
    // handshake.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("ready_in_reset", 64'(req_ready), 64'd0);
            phase       = 0;
            modelLast   = N - 1;
            sb.delete();
            grantedMask = '0;
        end else if (phase == 0) begin
            checkOutput("busy_idle", 64'(busy), 64'd0);
            checkOutput("valid_idle", 64'(resp_valid), 64'd0);
            mg = rrPick(req_valid, modelLast);
            if (mg < 0) begin
                checkOutput("ready_none", 64'(req_ready), 64'd0);
            end else begin
                checkOutput("grant", 64'(req_ready), 64'd1 << mg);
                actualIdx = -1;
                for (int i = 0; i < N; i++)
                    if (req_ready[i] && actualIdx < 0) actualIdx = i;
                grantLog.push_back(actualIdx);
                if (opQ[mg].size() != 0)
                    sb.push_back('{id: IDW'(mg),
                                   data: refLut(opQ[mg][0].a, opQ[mg][0].b, opQ[mg][0].f)});
                grantedMask[mg] = 1'b1;
                modelLast       = mg;
                phase           = 1;
                acceptCyc       = cyc;
            end
        end else begin
            checkOutput("ready_busy", 64'(req_ready), 64'd0);
            checkOutput("busy_active", 64'(busy), 64'd1);
            checkOutput("valid_timing", 64'(resp_valid),
                        64'(cyc >= acceptCyc + W + 1));
            if (cyc >= acceptCyc + W + 1 && resp_ready) phase = 0;
        end
    end

    // Response monitor. When a result is first presented, it pops the
    // scoreboard and compares. For as long as the result stays valid, it
    // checks that the result is held steady.
    always @(negedge clk) begin
        if (rst) begin
            prevValid = 1'b0;
            haveHeld  = 1'b0;
        end else begin
            if (resp_valid && !prevValid) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_resp: got data %0h id %0h, expected no response",
                             resp_data, resp_id);
                    haveHeld = 1'b0;
                end else begin
                    popped = sb.pop_front();
                    checkOutput("resp_data", 64'(resp_data), 64'(popped.data));
                    checkOutput("resp_id", 64'(resp_id), 64'(popped.id));
                    held     = popped;
                    haveHeld = 1'b1;
                end
                lastRespData = resp_data;
                lastRespId   = resp_id;
            end else if (resp_valid && prevValid && haveHeld) begin
                checkOutput("hold_data", 64'(resp_data), 64'(held.data));
                checkOutput("hold_id", 64'(resp_id), 64'(held.id));
            end
            prevValid = resp_valid;
        end
    end

    initial begin
        logic [3:0] sweepF[4];
        logic [7:0] sweepE[4];
        int rrExp[5];
        int rr2Exp[4];
        int n;

        sweepF = '{4'b1000, 4'b1110, 4'b0001, 4'b1100};
        sweepE = '{8'hC0, 8'hFC, 8'h03, 8'hF0};
        rrExp  = '{0, 1, 2, 3, 0};
        rr2Exp = '{1, 3, 1, 3};

        compared    = 0;
        mismatched  = 0;
        cyc         = 0;
        phase       = 0;
        acceptCyc   = 0;
        modelLast   = N - 1;
        grantedMask = '0;
        randomBp    = 1'b0;
        prevValid   = 1'b0;
        haveHeld    = 1'b0;
        rst         = 1'b1;
        resp_ready  = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        req_func    = '0;
        cValid      = '0;
        cA          = '0;
        cB          = '0;
        cFunc       = '0;
        cRespReady  = 1'b0;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset_data", 64'(resp_data), 64'd0);
        checkOutput("reset_id", 64'(resp_id), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("corner_reset_data", 64'(cData), 64'd0);

        // Single XOR operation from requester 0.
        @(posedge clk);
        applyStimulus(0, 8'hCA, 8'h5F, 4'b0110);
        waitIdle(200);
        checkOutput("xor_data", 64'(lastRespData), 64'h95);
        checkOutput("xor_id", 64'(lastRespId), 64'd0);

        // Function sweep from requester 2.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2, 8'hF0, 8'hCC, sweepF[k]);
            waitIdle(200);
            checkOutput("sweep_data", 64'(lastRespData), 64'(sweepE[k]));
            checkOutput("sweep_id", 64'(lastRespId), 64'd2);
        end

        // Leave requester 3 as the last grant, so the next search starts at 0.
        applyStimulus(3, 8'h12, 8'h34, 4'b0110);
        waitIdle(200);

        // Round-robin with all four requesters asking.
        grantLog.delete();
        applyStimulus(0, W'($urandom), W'($urandom), 4'($urandom));
        applyStimulus(1, W'($urandom), W'($urandom), 4'($urandom));
        applyStimulus(2, W'($urandom), W'($urandom), 4'($urandom));
        applyStimulus(3, W'($urandom), W'($urandom), 4'($urandom));
        applyStimulus(0, W'($urandom), W'($urandom), 4'($urandom));
        waitIdle(400);
        for (int k = 0; k < 5; k++)
            checkOutput("rr_order", 64'((k < grantLog.size()) ? grantLog[k] : -1),
                        64'(rrExp[k]));

        // Only requesters 1 and 3 asking: grants alternate between them.
        grantLog.delete();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, W'($urandom), W'($urandom), 4'($urandom));
            applyStimulus(3, W'($urandom), W'($urandom), 4'($urandom));
        end
        waitIdle(400);
        for (int k = 0; k < 4; k++)
            checkOutput("rr_pair_order", 64'((k < grantLog.size()) ? grantLog[k] : -1),
                        64'(rr2Exp[k]));

        // Back-pressure: hold DONE for several cycles while others wait.
        @(posedge clk);
        #2 resp_ready = 1'b0;
        applyStimulus(1, W'($urandom), W'($urandom), 4'($urandom));
        applyStimulus(0, W'($urandom), W'($urandom), 4'($urandom));
        applyStimulus(2, W'($urandom), W'($urandom), 4'($urandom));
        n = 0;
        while (!resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_reached_done", 64'(resp_valid), 64'd1);
        repeat (5) @(negedge clk);
        checkOutput("bp_busy", 64'(busy), 64'd1);
        checkOutput("bp_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #2 resp_ready = 1'b1;
        waitIdle(400);

        // Random traffic with random consumer stalls.
        randomBp = 1'b1;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(int'($urandom_range(0, N - 1)), W'($urandom),
                          W'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 8)) @(posedge clk);
        end
        waitIdle(5000);
        randomBp = 1'b0;
        @(posedge clk);
        #2 resp_ready = 1'b1;

        // Reset in the middle of an operation from requester 2.
        @(posedge clk);
        applyStimulus(2, 8'hA5, 8'h3C, 4'b0110);
        n = 0;
        while (phase == 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        checkOutput("midrun_started", 64'(phase), 64'd1);
        while (cyc < acceptCyc + 4 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #2 rst = 1'b1;
        for (int i = 0; i < N; i++) opQ[i].delete();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("midrun_valid", 64'(resp_valid), 64'd0);
        checkOutput("midrun_data", 64'(resp_data), 64'd0);
        checkOutput("midrun_id", 64'(resp_id), 64'd0);
        checkOutput("midrun_busy", 64'(busy), 64'd0);
        grantLog.delete();
        @(posedge clk);
        applyStimulus(0, 8'h0F, 8'h33, 4'b1110);
        applyStimulus(1, 8'hFF, 8'h00, 4'b1000);
        waitIdle(400);
        checkOutput("post_reset_first", 64'((grantLog.size() > 0) ? grantLog[0] : -1), 64'd0);
        checkOutput("post_reset_second", 64'((grantLog.size() > 1) ? grantLog[1] : -1), 64'd1);

        // WIDTH=1, N_REQ=1 corner.
        @(posedge clk);
        #2;
        cValid     = 1'b1;
        cA         = 1'b1;
        cB         = 1'b0;
        cFunc      = 4'b0100;
        cRespReady = 1'b0;
        @(negedge clk);
        checkOutput("corner_ready", 64'(cReady), 64'd1);
        @(posedge clk);
        #2 cValid = 1'b0;
        @(negedge clk);
        checkOutput("corner_run_valid", 64'(cRespValid), 64'd0);
        checkOutput("corner_run_busy", 64'(cBusy), 64'd1);
        @(negedge clk);
        checkOutput("corner_valid", 64'(cRespValid), 64'd1);
        checkOutput("corner_data", 64'(cData), 64'd1);
        checkOutput("corner_id", 64'(cId), 64'd0);
        @(posedge clk);
        #2 cRespReady = 1'b1;
        @(negedge clk);
        checkOutput("corner_hold", 64'(cRespValid), 64'd1);
        @(negedge clk);
        checkOutput("corner_released", 64'(cRespValid), 64'd0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
